regfile_sequencer: RTL

Initiator-side controller for the 16-entry, 32-bit register file. It accepts decoded register-register instructions over a valid/ready handshake and sequences the file's single-port protocol: a read phase that fetches rs/rt into the registered A/B outputs, an execute cycle, and a one-cycle write-back of the result to rd. It sits between instruction decode and the register file. It is the only agent allowed to drive the file's `we`, address and `regIn` inputs.

---
 rtl/regfile_seq_pkg.sv | 29 ++
 rtl/seq_alu.sv | 38 +++
 rtl/regfile_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg
// Shared definitions for the register-file sequencer and its ALU:
//   DATA_W / ADDR_W  register data width and register address width
//   op_e             3-bit operation encodings
//   state_e          sequencer FSM states
package regfile_seq_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_SLL = 3'b110,
      OP_NOR = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_e;

endpackage

// File: rtl/seq_alu.sv
// seq_alu
// Purely combinational ALU for register-register operations.
// Ports:
//   op_i      operation code (op_e)
//   a_i, b_i  operands (DATA_W)
//   result_o  operation result (DATA_W); arithmetic wraps, no flags
module seq_alu
   import regfile_seq_pkg::*;
(
   input  op_e               op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o
);

   // Shift amount uses only the low bits of B, so a shift of 35 acts as 3.
   localparam int SHAMT_W = $clog2(DATA_W);

   logic slt_bit;

   assign slt_bit = ($signed(a_i) < $signed(b_i));

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, slt_bit};
         OP_SLL:  result_o = a_i << b_i[SHAMT_W-1:0];
         OP_NOR:  result_o = ~(a_i | b_i);
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Accepts decoded register-register instructions over valid/ready and drives
// the single-port register file through READ -> EXEC -> WRITE, one
// instruction every four cycles.
// Ports:
//   Clk, reset                        clock, asynchronous active-high reset
//   instr_valid / instr_ready         instruction handshake
//   instr_op, instr_rs/rt/rd          decoded instruction fields
//   rf_we                             1 = read, 0 = write (low only in WRITE)
//   rf_addressA/B/In, rf_regIn        register file address and write data
//   rf_A, rf_B                        registered read data from the file
//   result                            last written-back value
//   done                              one-cycle pulse per completed instruction
module regfile_sequencer
   import regfile_seq_pkg::*;
(
   input  logic              Clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_rs,
   input  logic [ADDR_W-1:0] instr_rt,
   input  logic [ADDR_W-1:0] instr_rd,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addressA,
   output logic [ADDR_W-1:0] rf_addressB,
   output logic [ADDR_W-1:0] rf_addressIn,
   output logic [DATA_W-1:0] rf_regIn,
   input  logic [DATA_W-1:0] rf_A,
   input  logic [DATA_W-1:0] rf_B,
   output logic [DATA_W-1:0] result,
   output logic              done
);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] alu_result;
   logic              done_q;
   logic              accept;

   assign accept = instr_valid && (state_q == IDLE);

   seq_alu u_alu (
      .op_i     (op_q),
      .a_i      (rf_A),
      .b_i      (rf_B),
      .result_o (alu_result)
   );

   // rf_we is decoded straight from the state register: the asynchronous
   // reset forcing IDLE also forces rf_we high at once, so an interrupted
   // WRITE never reaches the file.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      rf_we       = 1'b1;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (accept) state_d = READ;
         end
         READ:  state_d = EXEC;
         EXEC:  state_d = WRITE;
         WRITE: begin
            rf_we   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= op_e'(instr_op);
            rs_q <= instr_rs;
            rt_q <= instr_rt;
            rd_q <= instr_rd;
         end
         // rf_A/rf_B carry the operands only during EXEC.
         if (state_q == EXEC) result_q <= alu_result;
         done_q <= (state_q == WRITE);
      end
   end

   // The write data and the visible result are one register, so the value
   // written back is exactly the value reported.
   assign rf_addressA  = rs_q;
   assign rf_addressB  = rt_q;
   assign rf_addressIn = rd_q;
   assign rf_regIn     = result_q;
   assign result       = result_q;
   assign done         = done_q;

endmodule
